// File: rtl/gps_fe_sample_capture.sv
// GPS front-end sample capture: oversamples the asynchronous front-end clock,
// packs sign/magnitude samples into words and queues them in a small FIFO.
module gps_fe_sample_capture #(
  parameter int SAMPLE_W    = 2,
  parameter int PACK        = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           CLOCK_50,
  input  logic                           reset_n,
  input  logic                           fe_clk,
  input  logic [SAMPLE_W-1:0]            fe_data,
  input  logic                           enable,
  output logic [SAMPLE_W*PACK-1:0]       word_out,
  output logic                           word_valid,
  input  logic                           word_ready,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           overflow,
  input  logic                           clear_overflow,
  output logic [15:0]                    drop_count
);

  localparam int WORD_W = SAMPLE_W * PACK;
  localparam int IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [SYNC_STAGES-1:0]               clk_sync;
  logic [SYNC_STAGES-1:0][SAMPLE_W-1:0] data_sync;
  logic                                 clk_d_p0;
  logic                                 fe_edge;
  logic                                 vld_p1;
  logic [SAMPLE_W-1:0]                  data_p1;
  logic [PACK-1:0][SAMPLE_W-1:0]        pack_p2;
  logic [PACK-1:0][SAMPLE_W-1:0]        pack_next;
  logic [IDX_W-1:0]                     idx_p2;
  logic                                 capture;
  logic                                 push;
  logic [WORD_W-1:0]                    push_word;

  logic [WORD_W-1:0]                    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                     wr_ptr;
  logic [PTR_W-1:0]                     rd_ptr;
  logic [LVL_W-1:0]                     level;
  logic                                 full;
  logic                                 pop;
  logic                                 wr_en;
  logic                                 drop;

  // Stage p0: clock and data share one chain depth so they stay aligned
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '0;
      data_sync <= '0;
      clk_d_p0  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], fe_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], fe_data};
      clk_d_p0  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fe_edge = clk_sync[SYNC_STAGES-1] & ~clk_d_p0;

  // Stage p1: registered edge strobe with its sample
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= fe_edge;
      data_p1 <= data_sync[SYNC_STAGES-1];
    end
  end

  assign capture = vld_p1 & enable;
  assign push    = capture & (idx_p2 == IDX_LAST);

  always_comb begin
    pack_next         = pack_p2;
    pack_next[idx_p2] = data_p1;
  end

  assign push_word = pack_next;

  // Stage p2: packer; the word is pushed in the same cycle as its last sample
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pack_p2 <= '0;
      idx_p2  <= '0;
    end else if (!enable) begin
      idx_p2  <= '0;
    end else if (capture) begin
      pack_p2 <= pack_next;
      idx_p2  <= push ? '0 : idx_p2 + IDX_W'(1);
    end
  end

  assign full       = (level == LVL_FULL);
  assign word_valid = (level != '0);
  assign pop        = word_valid & word_ready;
  assign wr_en      = push & (~full | pop);
  assign drop       = push & full & ~pop;
  assign word_out   = mem[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Clear has priority over a drop landing in the same cycle
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= sat_inc16(drop_count);
    end
  end

endmodule

// File: tb/tb_gps_fe_sample_capture.sv
// Randomized bench for gps_fe_sample_capture with a sample-list / word-queue
// reference model of packing, FIFO ordering, drops and clears.
module tb_gps_fe_sample_capture;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        fe_clk = 1'b0;
  logic [1:0]  fe_data = 2'd0;
  logic        enable = 1'b0;
  logic        word_ready = 1'b0;
  logic        clear_overflow = 1'b0;
  logic [15:0] word_out;
  logic        word_valid;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;

  gps_fe_sample_capture dut (
    .CLOCK_50       (CLOCK_50),
    .reset_n        (reset_n),
    .fe_clk         (fe_clk),
    .fe_data        (fe_data),
    .enable         (enable),
    .word_out       (word_out),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .drop_count     (drop_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [1:0]  m_samp[$];
  logic        m_ovf = 1'b0;
  logic [15:0] m_drop = 16'd0;
  int          popped = 0;
  int          valid_cycles = 0;
  logic [15:0] last_word = 16'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consumer side: every accepted word must match the head of the model queue
  always @(negedge CLOCK_50) begin
    if (reset_n && word_valid) valid_cycles++;
    if (reset_n && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        check_val("word_expected_on_pop", 32'(exp_q.size()), 32'd1);
      end else begin
        check_val("word", 32'(word_out), 32'(exp_q.pop_front()));
        last_word = word_out;
        popped++;
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic model_latch(input logic [1:0] s, input bit clr);
    logic [15:0] w;
    if (!enable) begin
      m_samp.delete();
    end else begin
      m_samp.push_back(s);
      if (m_samp.size() == 8) begin
        w = '0;
        for (int i = 0; i < 8; i++) w[i*2 +: 2] = m_samp[i];
        m_samp.delete();
        if (exp_q.size() < 16) exp_q.push_back(w);
        else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop++;
        end
      end
    end
    if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 16'd0;
    end
  endtask

  // One fe_clk period of 8 system cycles; the sample lands on the 4th edge.
  // mode 1: one-cycle ready pulse on the push edge; 2: latency probe; 3: clear on push edge.
  task automatic send_sample(input logic [1:0] s, input int mode);
    fe_data = s;
    fe_clk  = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      if (t == 4 && mode == 1) word_ready = 1'b1;
      if (t == 4 && mode == 3) clear_overflow = 1'b1;
      tick();
      if (t == 3 && mode == 2) check_val("latency_not_yet", 32'(word_valid), 32'd0);
      if (t == 4) begin
        if (mode == 1) word_ready = 1'b0;
        if (mode == 3) clear_overflow = 1'b0;
        model_latch(s, mode == 3);
        if (mode == 2) check_val("latency_valid", 32'(word_valid), 32'd1);
        fe_clk = 1'b0;
      end
    end
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_sample(2'($urandom), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    m_samp.delete();
    m_ovf  = 1'b0;
    m_drop = 16'd0;
  endtask

  task automatic pulse_clear();
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    m_ovf  = 1'b0;
    m_drop = 16'd0;
  endtask

  task automatic check_status(input string tag);
    check_val({tag, "_level"}, 32'(fifo_level), 32'(exp_q.size()));
    check_val({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    check_val({tag, "_drops"}, 32'(drop_count), 32'(m_drop));
  endtask

  task automatic drain(input string tag);
    word_ready = 1'b1;
    repeat (20) tick();
    check_val({tag, "_drained_level"}, 32'(fifo_level), 32'd0);
    check_val({tag, "_model_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic seen;

    // Reset with random inputs
    for (int i = 0; i < 6; i++) begin
      fe_clk         = 1'($urandom);
      fe_data        = 2'($urandom);
      enable         = 1'($urandom);
      word_ready     = 1'($urandom);
      clear_overflow = 1'($urandom);
      tick();
      check_val("reset_word_out", 32'(word_out), 32'd0);
      check_val("reset_flags", 32'({word_valid, fifo_level, overflow, drop_count}), 32'd0);
    end
    fe_clk = 1'b0;
    clear_overflow = 1'b0;
    word_ready = 1'b0;
    enable = 1'b1;
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      tick();
      seen = seen | word_valid;
    end
    check_val("idle_no_valid", 32'(seen), 32'd0);

    // Basic packing
    word_ready = 1'b1;
    popped = 0;
    valid_cycles = 0;
    send_sample(2'd0, 0); send_sample(2'd1, 0); send_sample(2'd2, 0); send_sample(2'd3, 0);
    send_sample(2'd0, 0); send_sample(2'd1, 0); send_sample(2'd2, 0); send_sample(2'd3, 0);
    repeat (4) tick();
    check_val("basic_words", 32'(popped), 32'd1);
    check_val("basic_word_value", 32'(last_word), 32'h0000E4E4);
    check_val("basic_valid_cycles", 32'(valid_cycles), 32'd1);
    check_val("basic_level", 32'(fifo_level), 32'd0);

    // Backpressure and overflow
    word_ready = 1'b0;
    for (int i = 0; i < 136; i++) send_sample(2'($urandom), (i == 7) ? 2 : 0);
    check_val("bp_level", 32'(fifo_level), 32'd16);
    check_val("bp_overflow", 32'(overflow), 32'd1);
    check_val("bp_drops", 32'(drop_count), 32'd1);
    check_status("bp");
    popped = 0;
    drain("bp");
    check_val("bp_read_count", 32'(popped), 32'd16);

    // Partial word discard
    pulse_clear();
    check_val("clear_overflow", 32'(overflow), 32'd0);
    check_val("clear_drops", 32'(drop_count), 32'd0);
    popped = 0;
    send_random(5);
    enable = 1'b0;
    m_samp.delete();
    repeat (3) tick();
    enable = 1'b1;
    repeat (8) send_sample(2'b11, 0);
    repeat (4) tick();
    check_val("partial_words", 32'(popped), 32'd1);
    check_val("partial_word_value", 32'(last_word), 32'h0000FFFF);
    check_val("partial_overflow", 32'(overflow), 32'd0);

    // Full FIFO with push and pop in the same cycle
    word_ready = 1'b0;
    send_random(128 + 7);
    check_val("simul_full_before", 32'(fifo_level), 32'd16);
    send_sample(2'($urandom), 1);
    tick();
    check_val("simul_level", 32'(fifo_level), 32'd16);
    check_val("simul_overflow", 32'(overflow), 32'd0);
    check_status("simul");
    popped = 0;
    drain("simul");
    check_val("simul_read_count", 32'(popped), 32'd16);

    // Clear racing a drop
    word_ready = 1'b0;
    send_random(128 + 8);
    check_val("race_pre_overflow", 32'(overflow), 32'd1);
    check_val("race_pre_drops", 32'(drop_count), 32'd1);
    send_random(7);
    send_sample(2'($urandom), 3);
    check_val("race_overflow", 32'(overflow), 32'd0);
    check_val("race_drops", 32'(drop_count), 32'd0);
    check_status("race");
    drain("race");

    // Reset in the middle of a word
    word_ready = 1'b0;
    send_random(4);
    do_reset();
    send_random(7);
    check_val("rst_mid_level", 32'(fifo_level), 32'd0);
    check_val("rst_mid_valid", 32'(word_valid), 32'd0);
    send_random(1);
    check_val("rst_mid_level_after8", 32'(fifo_level), 32'd1);
    popped = 0;
    drain("rst_mid");
    check_val("rst_mid_read_count", 32'(popped), 32'd1);

    // Randomized mix of traffic, enable gaps, backpressure and clears
    word_ready = 1'b1;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 11))
        0, 1: word_ready = 1'($urandom);
        2: begin
          enable = 1'b0;
          m_samp.delete();
          send_random($urandom_range(1, 3));
          enable = 1'b1;
        end
        3: pulse_clear();
        default: send_random(1);
      endcase
      check_status("rand");
    end
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
